// File: rtl/dac_tx_serializer_pkg.sv
// Shared types and width helpers for the DAC transmit serializer.
package dac_tx_serializer_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StGap} tx_state_t;

  localparam int unsigned SentW = 12;

  // Counter width for a 0..n-1 count; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dac_tx_serializer_sample_fifo.sv
// Small sample FIFO between the DSP chain and the serializer FSM.
module dac_tx_serializer_sample_fifo
  import dac_tx_serializer_pkg::*;
#(
  parameter int unsigned Win   = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [Win-1:0]            wr_data,
  input  logic                      pop,
  output logic [Win-1:0]            head,
  output logic                      empty,
  output logic                      full,
  output logic [occ_w(DEPTH)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = occ_w(DEPTH);

  logic [Win-1:0]  mem [DEPTH];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            push;
  logic            do_pop;

  // Full is judged on last cycle's occupancy, so a same-cycle pop frees nothing.
  assign full   = (count == OccW'(DEPTH));
  assign empty  = (count == '0);
  assign push   = wr_en & ~full;
  assign do_pop = pop & ~empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + OccW'(push) - OccW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/dac_tx_serializer.sv
// Buffers parallel DSP samples and shifts them MSB-first over a 3-wire DAC link.
module dac_tx_serializer
  import dac_tx_serializer_pkg::*;
#(
  parameter int unsigned Win   = 16,
  parameter int unsigned DIV   = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Win-1:0]   data_in,
  input  logic             val_in,
  output logic             rdy_out,
  output logic             sclk,
  output logic             sdo,
  output logic             cs_n,
  output logic             busy,
  output logic             overflow,
  output logic [SentW-1:0] sent_cnt
);

  localparam int unsigned DivW = cnt_w(DIV);
  localparam int unsigned BitW = cnt_w(Win);
  localparam int unsigned OccW = occ_w(DEPTH);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(Win - 1);

  tx_state_t       state;
  logic [DivW-1:0] divcnt;
  logic [BitW-1:0] bitcnt;
  logic [Win-1:0]  shreg;

  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic [Win-1:0]  fifo_head;
  logic [OccW-1:0] fifo_count;

  assign pop     = (state == StIdle) & ~fifo_empty;
  assign rdy_out = ~fifo_full;
  assign busy    = (state != StIdle) | (fifo_count != '0);

  dac_tx_serializer_sample_fifo #(
    .Win   (Win),
    .DEPTH (DEPTH)
  ) u_sample_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (val_in),
    .wr_data (data_in),
    .pop     (pop),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      sclk     <= 1'b0;
      sdo      <= 1'b0;
      cs_n     <= 1'b1;
      divcnt   <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      sent_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (val_in && fifo_full) begin
        overflow <= 1'b1;
      end
      unique case (state)
        StIdle: begin
          if (!fifo_empty) begin
            shreg  <= fifo_head;
            sdo    <= fifo_head[Win-1];
            cs_n   <= 1'b0;
            sclk   <= 1'b0;
            divcnt <= '0;
            bitcnt <= '0;
            state  <= StShift;
          end
        end
        StShift: begin
          if (divcnt == DivLast) begin
            divcnt <= '0;
            sclk   <= ~sclk;
            // Data only moves on the falling toggle; the DAC samples on the rise.
            if (sclk) begin
              if (bitcnt == BitLast) begin
                cs_n     <= 1'b1;
                sdo      <= 1'b0;
                sent_cnt <= sent_cnt + 1'b1;
                state    <= StGap;
              end else begin
                bitcnt <= bitcnt + 1'b1;
                shreg  <= {shreg[Win-2:0], 1'b0};
                sdo    <= shreg[Win-2];
              end
            end
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        StGap: begin
          if (divcnt == DivLast) begin
            divcnt <= '0;
            state  <= StIdle;
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
